// File: rtl/mdu_sequencer.sv
// HI/LO owner and fixed-latency sequencer for MULT/MULTU/DIV/DIVU, plus
// single-cycle MTHI/MTLO writes. The result is computed at accept and released after LAT cycles.
module mdu_sequencer #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        cancel,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state, state_next;
    logic [3:0]  count;
    logic [31:0] hi_n, lo_n;
    logic [31:0] res_hi, res_lo;
    logic        eff_start, finish;
    logic        busy_next, done_next;

    assign eff_start = start & ~cancel & ~busy;
    assign finish    = (state != IDLE) && (count == 4'd1);

    // Result is formed from the operands present at accept, so later a/b changes are harmless.
    always_comb begin
        logic signed [31:0] sa, sb;
        logic signed [63:0] sprod;
        logic        [63:0] uprod;
        sa     = a;
        sb     = b;
        sprod  = sa * sb;
        uprod  = {32'd0, a} * {32'd0, b};
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            3'd0: {res_hi, res_lo} = sprod;
            3'd1: {res_hi, res_lo} = uprod;
            3'd2: begin
                if (b == 32'd0) begin
                    res_lo = 32'hFFFF_FFFF;
                    res_hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    // Overflow case: quotient wraps, remainder is zero.
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = sa / sb;
                    res_hi = sa % sb;
                end
            end
            3'd3: begin
                if (b == 32'd0) begin
                    res_lo = 32'hFFFF_FFFF;
                    res_hi = a;
                end else begin
                    res_lo = a / b;
                    res_hi = a % b;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (eff_start) begin
                if (op == 3'd0 || op == 3'd1)      state_next = MUL;
                else if (op == 3'd2 || op == 3'd3) state_next = DIV;
            end
            MUL, DIV: if (count == 4'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_next = (state_next != IDLE);
        done_next = finish;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            count <= 4'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            hi_n  <= 32'd0;
            lo_n  <= 32'd0;
        end else begin
            busy <= busy_next;
            done <= done_next;
            if (state == IDLE) begin
                if (eff_start) begin
                    case (op)
                        3'd0, 3'd1: begin
                            hi_n  <= res_hi;
                            lo_n  <= res_lo;
                            count <= 4'(MUL_LAT);
                        end
                        3'd2, 3'd3: begin
                            hi_n  <= res_hi;
                            lo_n  <= res_lo;
                            count <= 4'(DIV_LAT);
                        end
                        3'd4: hi <= a;
                        3'd5: lo <= a;
                        default: ;
                    endcase
                end
            end else begin
                count <= count - 4'd1;
                if (finish) begin
                    hi <= hi_n;
                    lo <= lo_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: latency, arithmetic, boundaries, MTHI/MTLO,
// cancel, start-while-busy and mid-flight reset.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [2:0]  op = 3'd7;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

    mdu_sequencer #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cancel(cancel),
        .op(op), .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Presents one start for one edge; returns in the cycle after that edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles with busy high; stops in the first cycle busy is low.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        start = 1'b1; op = 3'd4; a = 32'hAAAA_5555;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
        end
        start = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult;
        int n;
        issue(3'd0, 32'hFFFF_FFFF, 32'd2);
        vectors++;
        if (busy !== 1'b1 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL mult_early: got busy=%b hi=%h lo=%h, want busy=1 hi=0 lo=0", busy, hi, lo);
        end
        count_busy(n);
        vectors++;
        if (n != 5 || done !== 1'b1 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("FAIL mult_result: got lat=%0d done=%b hi=%h lo=%h, want lat=5 done=1 hi=ffffffff lo=fffffffe", n, done, hi, lo);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: got done=%b one cycle later, want 0", done);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        count_busy(n);
        vectors++;
        if (n != 5 || done !== 1'b1 || hi !== 32'd1 || lo !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("FAIL multu_result: got lat=%0d done=%b hi=%h lo=%h, want lat=5 done=1 hi=1 lo=fffffffe", n, done, hi, lo);
        end
        start = 1'b1; op = 3'd2; a = 32'hFFFF_FFF9; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept: got busy=%b done=%b, want busy=1 done=0", busy, done);
        end
        count_busy(n);
        vectors++;
        if (n != 10 || done !== 1'b1 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            miscompares++;
            $display("FAIL div_neg: got lat=%0d done=%b hi=%h lo=%h, want lat=10 done=1 hi=ffffffff lo=fffffffd", n, done, hi, lo);
        end
    endtask

    task automatic test_div_bounds;
        int n;
        issue(3'd3, 32'd100, 32'd0);
        count_busy(n);
        vectors++;
        if (n != 10 || hi !== 32'd100 || lo !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL divu_by_zero: got lat=%0d hi=%h lo=%h, want lat=10 hi=64 lo=ffffffff", n, hi, lo);
        end
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        vectors++;
        if (n != 10 || hi !== 32'd0 || lo !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL div_overflow: got lat=%0d hi=%h lo=%h, want lat=10 hi=0 lo=80000000", n, hi, lo);
        end
        issue(3'd2, 32'd7, 32'd0);
        count_busy(n);
        vectors++;
        if (n != 10 || hi !== 32'd7 || lo !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL div_by_zero: got lat=%0d hi=%h lo=%h, want lat=10 hi=7 lo=ffffffff", n, hi, lo);
        end
    endtask

    task automatic test_mt;
        issue(3'd4, 32'h1234_5678, 32'd0);
        vectors++;
        if (hi !== 32'h1234_5678 || lo !== 32'hFFFF_FFFF || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi: got hi=%h lo=%h busy=%b done=%b, want hi=12345678 lo=ffffffff busy=0 done=0", hi, lo, busy, done);
        end
        issue(3'd5, 32'h0BAD_F00D, 32'd0);
        vectors++;
        if (hi !== 32'h1234_5678 || lo !== 32'h0BAD_F00D || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mtlo: got hi=%h lo=%h busy=%b, want hi=12345678 lo=0badf00d busy=0", hi, lo, busy);
        end
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        vectors++;
        if (lo !== 32'h0BAD_F00D || hi !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL mtlo_cancel: got hi=%h lo=%h, want hi=12345678 lo=0badf00d", hi, lo);
        end
    endtask

    task automatic test_reset_midflight;
        bit bad;
        issue(3'd2, 32'd20, 32'd3);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL midflight_reset: got busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
        end
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL discarded_op: got late activity after reset (bad=%b), want none", bad);
        end
    endtask

    task automatic test_start_while_busy;
        int n;
        issue(3'd2, 32'd20, 32'd3);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == 2) begin
                start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        vectors++;
        if (n != 10 || done !== 1'b1 || hi !== 32'd2 || lo !== 32'd6) begin
            miscompares++;
            $display("FAIL start_while_busy: got lat=%0d done=%b hi=%h lo=%h, want lat=10 done=1 hi=2 lo=6", n, done, hi, lo);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_start: got busy=%b after done, want 0", busy);
        end
    endtask

    task automatic test_cancel_and_capture;
        int n;
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd6) begin
            miscompares++;
            $display("FAIL mult_cancel: got busy=%b hi=%h lo=%h, want busy=0 hi=2 lo=6", busy, hi, lo);
        end
        issue(3'd0, 32'd3, 32'd4);
        a = 32'd100; b = 32'd100;
        count_busy(n);
        vectors++;
        if (n != 5 || hi !== 32'd0 || lo !== 32'd12) begin
            miscompares++;
            $display("FAIL operand_capture: got lat=%0d hi=%h lo=%h, want lat=5 hi=0 lo=c", n, hi, lo);
        end
        issue(3'd6, 32'h5555_5555, 32'd9);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd12) begin
            miscompares++;
            $display("FAIL noop_op: got busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=c", busy, hi, lo);
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_back_to_back;
        test_div_bounds;
        test_mt;
        test_reset_midflight;
        test_start_while_busy;
        test_cancel_and_capture;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
